// File: rtl/insn_queue.sv
// Instruction queue between decode and issue: a circular buffer that accepts
// up to two decoded entries per cycle and presents a four-entry head window
// from which the issue stage retires one to four entries per cycle.

package iq_pkg;
  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] pc;
  } iq_entry_t;
endpackage

module insn_queue
  import iq_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       flush,
  input  logic [1:0] enq_valid,
  input  iq_entry_t  enq_insn [2],
  output logic       enq_ready,
  input  logic       ext_enable,
  input  logic [1:0] ext_consumed,
  output logic [3:0] ext_valid,
  output iq_entry_t  insns [4],
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  ptr_t      head_q, head_d;
  ptr_t      tail_q, tail_d;
  cnt_t      count_q, count_d;
  iq_entry_t mem_q [DEPTH];

  logic [2:0] npop;
  logic [1:0] npush;
  logic       wr_en0, wr_en1;
  ptr_t       wr_addr0, wr_addr1;
  iq_entry_t  wr_data0, wr_data1;

  // Head window and status flags, driven from registers only.
  always_comb begin
    enq_ready = (count_q <= cnt_t'(DEPTH - 2));
    empty     = (count_q == '0);
    for (int i = 0; i < 4; i++) begin
      ext_valid[i] = (count_q > cnt_t'(i));
      insns[i]     = mem_q[head_q + ptr_t'(i)];
    end
  end

  // Next pointers/count plus the two packed write ports for this cycle.
  always_comb begin
    // NOTE: every signal this block writes gets a default first, so no path
    // leaves one unassigned and no latch can be inferred.
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    npop     = '0;
    npush    = '0;
    wr_en0   = 1'b0;
    wr_en1   = 1'b0;
    wr_addr0 = tail_q;
    wr_addr1 = tail_q + ptr_t'(1);
    wr_data0 = enq_valid[0] ? enq_insn[0] : enq_insn[1];
    wr_data1 = enq_insn[1];

    if (reset || flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Over-requests are clamped to what is actually held.
      if (ext_enable) begin
        if (cnt_t'(ext_consumed) + cnt_t'(1) > count_q) begin
          npop = 3'(count_q);
        end else begin
          npop = 3'(ext_consumed) + 3'd1;
        end
      end
      // Valid slots are packed: the oldest valid one always lands at tail.
      if (enq_ready) begin
        npush  = 2'(enq_valid[0]) + 2'(enq_valid[1]);
        wr_en0 = |enq_valid;
        wr_en1 = &enq_valid;
      end
      head_d  = head_q + ptr_t'(npop);
      tail_d  = tail_q + ptr_t'(npush);
      count_d = count_q + cnt_t'(npush) - cnt_t'(npop);
    end
  end

  // Pointer and occupancy registers with synchronous reset.
  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of statement order.
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage: the two write addresses are always distinct.
  always_ff @(posedge clock) begin
    // NOTE: storage is deliberately not reset; stale contents are never
    // visible because ext_valid is derived from count alone.
    if (wr_en0) mem_q[wr_addr0] <= wr_data0;
    if (wr_en1) mem_q[wr_addr1] <= wr_data1;
  end

  // Issue must never ask to retire more entries than are queued.
  a_no_overpop : assert property (
    @(posedge clock) disable iff (reset || flush)
    !(ext_enable && (cnt_t'(ext_consumed) + cnt_t'(1) > count_q))
  ) else $warning("insn_queue: retire of %0d requested with %0d queued, clamped",
                  ext_consumed + 3'd1, count_q);

endmodule
